// File: rtl/rob_multi_port.sv
// rtl/rob_multi_port.sv - reorder buffer with multi-port random-slot insert and in-order head dequeue
module rob_multi_port #(
    parameter int p_msg_bits  = 32,
    parameter int p_depth     = 8,
    parameter int p_num_ins   = 2,
    parameter int p_addr_bits = $clog2(p_depth),
    parameter int p_cnt_bits  = $clog2(p_depth + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [p_num_ins-1:0]             ins_en,
    input  logic [p_num_ins*p_addr_bits-1:0] ins_idx,
    input  logic [p_num_ins*p_msg_bits-1:0]  ins_msg,
    input  logic                             deq_en,
    output logic                             deq_rdy,
    output logic [p_addr_bits-1:0]           deq_idx,
    output logic [p_msg_bits-1:0]            deq_msg,
    input  logic                             flush,
    output logic [p_cnt_bits-1:0]            count
);

    localparam logic [p_addr_bits-1:0] last_idx = p_addr_bits'(p_depth - 1);

    logic [p_depth-1:0]     valid;
    logic [p_depth-1:0]     valid_nxt;
    logic [p_addr_bits-1:0] head;
    logic [p_addr_bits-1:0] head_nxt;
    logic [p_cnt_bits-1:0]  count_nxt;
    logic [p_msg_bits-1:0]  payload [p_depth];

    logic [p_num_ins-1:0]   ins_ok;
    logic [p_addr_bits-1:0] idx_a [p_num_ins];
    logic [p_msg_bits-1:0]  msg_a [p_num_ins];
    logic                   deq_fire;

    // Indices past the last entry only exist for non-power-of-two depths; they are dropped.
    for (genvar g = 0; g < p_num_ins; g++) begin : g_unpack
        assign idx_a[g]  = ins_idx[g*p_addr_bits +: p_addr_bits];
        assign msg_a[g]  = ins_msg[g*p_msg_bits +: p_msg_bits];
        assign ins_ok[g] = ins_en[g] && (int'(idx_a[g]) < p_depth);
    end

    assign deq_fire = deq_en && valid[head];
    assign deq_rdy  = valid[head];
    assign deq_idx  = head;
    assign deq_msg  = payload[head];

    // Dequeue clears first so an insert at the head in the same cycle leaves it valid.
    always_comb begin
        valid_nxt = valid;
        head_nxt  = head;
        if (deq_fire) begin
            valid_nxt[head] = 1'b0;
            head_nxt        = (head == last_idx) ? '0 : head + 1'b1;
        end
        for (int p = 0; p < p_num_ins; p++) begin
            if (ins_ok[p]) valid_nxt[idx_a[p]] = 1'b1;
        end
        if (flush) begin
            valid_nxt = '0;
            head_nxt  = '0;
        end
        count_nxt = '0;
        for (int i = 0; i < p_depth; i++) begin
            count_nxt = count_nxt + p_cnt_bits'(valid_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            head  <= '0;
            count <= '0;
        end else begin
            valid <= valid_nxt;
            head  <= head_nxt;
            count <= count_nxt;
        end
    end

    // Payload is not reset; the highest-numbered port's write lands last on a collision.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int p = 0; p < p_num_ins; p++) begin
                if (ins_ok[p]) payload[idx_a[p]] <= msg_a[p];
            end
        end
    end

    // Packs {head, count, valid} for a debug display.
    function automatic logic [p_addr_bits+p_cnt_bits+p_depth-1:0] trace();
        return {head, count, valid};
    endfunction

endmodule

// File: tb/tb_rob_multi_port.sv
// tb/tb_rob_multi_port.sv - randomized and directed self-checking bench for rob_multi_port
module tb_rob_multi_port;

    localparam int D = 6;
    localparam int N = 2;
    localparam int W = 32;
    localparam int A = $clog2(D);
    localparam int C = $clog2(D + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   ins_en;
    logic [N*A-1:0] ins_idx;
    logic [N*W-1:0] ins_msg;
    logic           deq_en;
    logic           deq_rdy;
    logic [A-1:0]   deq_idx;
    logic [W-1:0]   deq_msg;
    logic           flush;
    logic [C-1:0]   count;

    rob_multi_port #(.p_msg_bits(W), .p_depth(D), .p_num_ins(N)) dut (
        .clk(clk), .rst(rst), .ins_en(ins_en), .ins_idx(ins_idx), .ins_msg(ins_msg),
        .deq_en(deq_en), .deq_rdy(deq_rdy), .deq_idx(deq_idx), .deq_msg(deq_msg),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit         m_valid [D];
    logic [W-1:0] m_msg [D];
    int         m_head;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ins_en  = '0;
        ins_idx = '0;
        ins_msg = '0;
        deq_en  = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic set_ins(input int p, input int idx, input logic [W-1:0] msg);
        ins_en[p]          = 1'b1;
        ins_idx[p*A +: A]  = A'(idx);
        ins_msg[p*W +: W]  = msg;
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
        m_head = 0;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    // Reference: flush wins; otherwise pop the head, then apply inserts in port order.
    task automatic model_step();
        int idx;
        if (flush) begin
            model_reset();
            return;
        end
        if (deq_en && m_valid[m_head]) begin
            m_valid[m_head] = 1'b0;
            m_head = (m_head + 1) % D;
        end
        for (int p = 0; p < N; p++) begin
            idx = int'(ins_idx[p*A +: A]);
            if (ins_en[p] && idx < D) begin
                m_valid[idx] = 1'b1;
                m_msg[idx]   = ins_msg[p*W +: W];
            end
        end
    endtask

    task automatic check_all();
        check("rdy", 64'(deq_rdy), 64'(m_valid[m_head]));
        check("idx", 64'(deq_idx), 64'(m_head));
        check("count", 64'(count), 64'(m_count()));
        if (m_valid[m_head]) check("msg", 64'(deq_msg), 64'(m_msg[m_head]));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        idle();
        check_all();
    endtask

    logic [W-1:0] ooo_exp [4];

    initial begin
        idle();
        model_reset();
        rst = 1'b0;
        #12;
        check("reset_rdy", 64'(deq_rdy), 64'd0);
        check("reset_idx", 64'(deq_idx), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic insert and pop
        set_ins(0, 0, 32'hdeadbeef);
        step();
        check("basic_rdy", 64'(deq_rdy), 64'd1);
        check("basic_idx", 64'(deq_idx), 64'd0);
        check("basic_msg", 64'(deq_msg), 64'hdeadbeef);
        check("basic_count", 64'(count), 64'd1);
        deq_en = 1'b1;
        step();
        check("basic_pop_count", 64'(count), 64'd0);
        check("basic_pop_head", 64'(deq_idx), 64'd1);

        // Out-of-order multi-port fill
        flush = 1'b1;
        step();
        set_ins(0, 3, 32'hFFFFFFFF);
        set_ins(1, 1, 32'h87654321);
        step();
        check("ooo_head_absent", 64'(deq_rdy), 64'd0);
        set_ins(0, 2, 32'h0);
        set_ins(1, 0, 32'h12345678);
        step();
        ooo_exp = '{32'h12345678, 32'h87654321, 32'h0, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            check("ooo_idx", 64'(deq_idx), 64'(i));
            check("ooo_msg", 64'(deq_msg), 64'(ooo_exp[i]));
            deq_en = 1'b1;
            step();
        end

        // Capacity and wrap
        flush = 1'b1;
        step();
        for (int k = 0; k < D / 2; k++) begin
            set_ins(0, 2*k, W'(2*k));
            set_ins(1, 2*k + 1, W'(2*k + 1));
            step();
        end
        check("full_count", 64'(count), 64'(D));
        for (int i = 0; i < D; i++) begin
            check("full_pop_msg", 64'(deq_msg), 64'(i));
            deq_en = 1'b1;
            step();
        end
        check("wrap_head", 64'(deq_idx), 64'd0);
        check("wrap_count", 64'(count), 64'd0);
        set_ins(0, 0, 32'h0);
        step();
        check("wrap_rdy", 64'(deq_rdy), 64'd1);
        deq_en = 1'b1;
        step();
        check("wrap_pop_head", 64'(deq_idx), 64'd1);

        // Same-index collision and insert-at-head during pop
        flush = 1'b1;
        step();
        set_ins(0, 2, 32'hAAAA);
        set_ins(1, 2, 32'hBBBB);
        step();
        check("coll_count", 64'(count), 64'd1);
        set_ins(0, 0, 32'h10);
        set_ins(1, 1, 32'h11);
        step();
        deq_en = 1'b1;
        step();
        deq_en = 1'b1;
        step();
        check("coll_msg", 64'(deq_msg), 64'hBBBB);
        deq_en = 1'b1;
        set_ins(0, 2, 32'hCCCC);
        step();
        check("hitpop_count", 64'(count), 64'd1);
        check("hitpop_head", 64'(deq_idx), 64'd3);
        set_ins(0, 3, 32'h3);
        set_ins(1, 4, 32'h4);
        step();
        set_ins(0, 5, 32'h5);
        set_ins(1, 0, 32'h0);
        step();
        set_ins(0, 1, 32'h1);
        step();
        for (int i = 0; i < 5; i++) begin
            deq_en = 1'b1;
            step();
        end
        check("hitpop_rdy", 64'(deq_rdy), 64'd1);
        check("hitpop_msg", 64'(deq_msg), 64'hCCCC);

        // Flush beats simultaneous insert and dequeue
        flush = 1'b1;
        step();
        set_ins(0, 0, 32'h50);
        set_ins(1, 1, 32'h51);
        step();
        set_ins(0, 2, 32'h52);
        set_ins(1, 3, 32'h53);
        step();
        set_ins(0, 4, 32'h54);
        step();
        check("flush_pre_count", 64'(count), 64'd5);
        flush  = 1'b1;
        deq_en = 1'b1;
        set_ins(0, 5, 32'h55);
        step();
        check("flush_count", 64'(count), 64'd0);
        check("flush_head", 64'(deq_idx), 64'd0);
        check("flush_rdy", 64'(deq_rdy), 64'd0);

        // Asynchronous reset between edges
        set_ins(0, 0, 32'h70);
        set_ins(1, 1, 32'h71);
        step();
        set_ins(0, 2, 32'h72);
        step();
        check("areset_pre_count", 64'(count), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        check("areset_rdy", 64'(deq_rdy), 64'd0);
        check("areset_count", 64'(count), 64'd0);
        check("areset_idx", 64'(deq_idx), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        set_ins(0, 0, 32'h99);
        step();
        check("post_reset_count", 64'(count), 64'd1);

        // Randomized traffic, including out-of-range indices and rare flushes
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 2) != 0) set_ins(p, int'($urandom_range(0, 7)), $urandom);
            end
            deq_en = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 40) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
